rpn_stack_ctrl: RTL
===================

// Module: rpn_stack_ctrl
// PURPOSE
//  Reverse-Polish token sequencer sitting directly upstream of the LIFO stack block.
//  Accepts a stream of operand/operator tokens over a valid/ready handshake.
//  Drives the stack's push/pop/write-data port; evaluates arithmetic on popped operands.
//  Emits results on a downstream valid/ready port. Underflow, overflow and illegal
//  opcodes latch a sticky error.
// PARAMETERS
//  WIDTH  8  data/operand width, two's complement; must match the stack's WIDTH
//  OPW    3  opcode field width, taken from tok_data[OPW-1:0] when tok_is_op=1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  tok_valid  in   1      token present
//  tok_ready  out  1      token accepted when tok_valid && tok_ready
//  tok_is_op  in   1      1 = operator token, 0 = operand token
//  tok_data   in   WIDTH  operand value, or opcode in [OPW-1:0]
//  stk_push   out  1      push strobe to stack
//  stk_pop    out  1      pop strobe to stack
//  stk_wdata  out  WIDTH  push data
//  stk_rdata  in   WIDTH  top-of-stack; valid combinationally while stk_pop=1
//  stk_full   in   1      stack full
//  stk_empty  in   1      stack empty
//  res_valid  out  1      result present; held until res_ready
//  res_ready  in   1      downstream accepts result
//  res_data   out  WIDTH  result value
//  err        out  1      sticky error
//  err_code   out  2      0 none, 1 underflow, 2 overflow, 3 illegal opcode
//  err_clr    in   1      synchronous clear of err/err_code; FSM returns to IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE. All outputs 0: tok_ready, stk_push, stk_pop, stk_wdata, res_valid,
//   res_data, err, err_code. Operand regs A/B are 0.
//  Reset asserted mid-operation aborts it immediately. No stack strobe is issued after
//   the reset edge.
//  Opcodes: 0 ADD a+b, 1 SUB a-b, 2 MUL low WIDTH bits of a*b, 3 NEG -b, 4 DUP b,b,
//   5 DROP, 6 EMIT, 7 illegal.
//   Here b = first pop (top of stack) and a = second pop.
//  Arithmetic: signed, wraps modulo 2^WIDTH. No saturation and no overflow flag.
//  tok_ready=1 only in IDLE with err=0. Tokens are accepted one at a time.
//  States:
//   IDLE
//    operand -> PUSH, B<=tok_data.
//    operator 0-2 -> POP_B.
//    operator 3-6 -> POP_B.
//    operator 7 -> ERR, code 3.
//   POP_B
//    stk_empty=1 -> ERR, code 1, stk_pop stays 0.
//    Otherwise stk_pop=1 and B<=stk_rdata.
//    Next: binary op -> POP_A; NEG/DUP -> EXEC; DROP -> IDLE; EMIT -> EMIT.
//   POP_A
//    Same empty check as POP_B. stk_pop=1, A<=stk_rdata, next EXEC.
//   EXEC
//    R<=alu(op,A,B), next PUSH. For DUP, R=B and two pushes follow.
//   PUSH
//    stk_full=1 -> ERR, code 2, no push.
//    Otherwise stk_push=1 with stk_wdata=R (or B for operands), for one cycle.
//    Next IDLE, or PUSH again for DUP's second copy.
//   EMIT
//    res_valid=1, res_data=B. Stays until res_ready; then res_valid=0 next cycle, -> IDLE.
//   ERR
//    err=1, all strobes 0, tok_ready=0. Leaves only on err_clr or reset.
//  Latency, token accept to last strobe:
//   operand 1 cycle; NEG 3; binary op 4; DUP 4; DROP 1.
//  stk_push and stk_pop are never asserted in the same cycle. Each is asserted at most
//   once per state visit.
//  Stack state is sampled only in the cycle of the strobe decision. A pop that underflows
//   leaves earlier pops of the same token committed; no rollback.
//  err_clr while not in ERR has no effect. err_clr and a new token in the same cycle:
//   the clear wins, and the token is not accepted.
// STRUCTURE
//  Package rpn_pkg: opcode constants, state encoding, err_code constants.
//  Sub-module rpn_alu: combinational (op, a, b) -> r with WIDTH wrap rules.
//  The FSM and handshake logic live in this module.
// TESTING
//  Bench pairs this block with the stack, DEPTH=4.
//  1. Push 5, push 3, ADD, EMIT -> res_data=8. Stack empty afterwards. err=0.
//  2. Push 2, push 7, SUB -> top=-5 (8'hFB). Then MUL by 100 -> wraps to 8'h0C.
//  3. ADD on an empty stack -> err=1, err_code=1, no stk_pop. err_clr -> IDLE, tok_ready=1.
//  4. Push 4 operands, then a 5th -> err_code=2, no stk_push. DUP on a full stack -> code 2.
//  5. EMIT with res_ready held low 5 cycles -> res_valid and res_data stable.
//     tok_ready=0 throughout.
//  6. rst_n low in POP_A of a MUL -> all outputs 0 asynchronously. No further strobes.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN token sequencer: widths, opcodes, FSM states, error codes.
// The opcode set is defined for a 3-bit opcode field.
package rpn_pkg;

   localparam int unsigned RPN_WIDTH = 8;
   localparam int unsigned RPN_OPW   = 3;
   localparam int unsigned RPN_ECW   = 2;

   typedef enum logic [RPN_OPW-1:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_MUL  = 3'd2,
      OP_NEG  = 3'd3,
      OP_DUP  = 3'd4,
      OP_DROP = 3'd5,
      OP_EMIT = 3'd6,
      OP_ILL  = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_POP_B = 3'd1,
      ST_POP_A = 3'd2,
      ST_EXEC  = 3'd3,
      ST_PUSH  = 3'd4,
      ST_EMIT  = 3'd5,
      ST_ERR   = 3'd6
   } state_e;

   typedef enum logic [RPN_ECW-1:0] {
      ERR_NONE  = 2'd0,
      ERR_UNDER = 2'd1,
      ERR_OVER  = 2'd2,
      ERR_ILL   = 2'd3
   } err_e;

   // Operators that need a second operand (A) popped after B.
   function automatic logic is_binary(input op_e op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational RPN arithmetic: r = op(a, b), all results wrap modulo 2^WIDTH.
// b is the first-popped (top) operand, a the second.
module rpn_alu
   import rpn_pkg::*;
#(
   parameter int unsigned WIDTH = RPN_WIDTH
) (
   input  op_e              i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_r_c
);

   localparam int unsigned PW = 2 * WIDTH;

   logic [PW-1:0] w_prod;

   // Low WIDTH bits of the product are identical for signed and unsigned operands.
   assign w_prod = PW'(i_a) * PW'(i_b);

   always_comb begin
      o_r_c = i_b;
      case (i_op)
         OP_ADD:  o_r_c = i_a + i_b;
         OP_SUB:  o_r_c = i_a - i_b;
         OP_MUL:  o_r_c = w_prod[WIDTH-1:0];
         OP_NEG:  o_r_c = WIDTH'(0) - i_b;
         default: o_r_c = i_b;
      endcase
   end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Reverse-Polish token sequencer driving a LIFO stack's push/pop port.
// Stack strobes are decided in-state from live stack flags; all other outputs are registered.
module rpn_stack_ctrl
   import rpn_pkg::*;
#(
   parameter int unsigned WIDTH = RPN_WIDTH,
   parameter int unsigned OPW   = RPN_OPW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tok_valid,
   output logic             tok_ready,
   input  logic             tok_is_op,
   input  logic [WIDTH-1:0] tok_data,
   output logic             stk_push,
   output logic             stk_pop,
   output logic [WIDTH-1:0] stk_wdata,
   input  logic [WIDTH-1:0] stk_rdata,
   input  logic             stk_full,
   input  logic             stk_empty,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             err,
   output logic [1:0]       err_code,
   input  logic             err_clr
);

   state_e           r_state,    w_state_nxt;
   op_e              r_op,       w_op_nxt;
   logic [WIDTH-1:0] r_a,        w_a_nxt;
   logic [WIDTH-1:0] r_b,        w_b_nxt;
   logic [WIDTH-1:0] r_wdata,    w_wdata_nxt;
   logic [WIDTH-1:0] r_res_data, w_res_data_nxt;
   logic             r_dup_pend, w_dup_nxt;
   err_e             r_err_code, w_code_nxt;
   logic             r_tok_ready;
   logic             r_res_valid;
   logic             r_err;
   logic             w_push_c;
   logic             w_pop_c;
   logic [WIDTH-1:0] w_alu_c;
   op_e              w_tok_op;

   assign w_tok_op = op_e'(RPN_OPW'(tok_data[OPW-1:0]));

   rpn_alu #(.WIDTH(WIDTH)) u_alu (
      .i_op  (r_op),
      .i_a   (r_a),
      .i_b   (r_b),
      .o_r_c (w_alu_c)
   );

   // State register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_ADD;
         r_a         <= '0;
         r_b         <= '0;
         r_wdata     <= '0;
         r_res_data  <= '0;
         r_dup_pend  <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_tok_ready <= 1'b0;
         r_res_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_op        <= w_op_nxt;
         r_a         <= w_a_nxt;
         r_b         <= w_b_nxt;
         r_wdata     <= w_wdata_nxt;
         r_res_data  <= w_res_data_nxt;
         r_dup_pend  <= w_dup_nxt;
         r_err_code  <= w_code_nxt;
         r_tok_ready <= (w_state_nxt == ST_IDLE);
         r_res_valid <= (w_state_nxt == ST_EMIT);
         r_err       <= (w_state_nxt == ST_ERR);
      end
   end

   // Next-state, datapath updates and stack strobes.
   always_comb begin
      w_state_nxt    = r_state;
      w_op_nxt       = r_op;
      w_a_nxt        = r_a;
      w_b_nxt        = r_b;
      w_wdata_nxt    = r_wdata;
      w_res_data_nxt = r_res_data;
      w_dup_nxt      = r_dup_pend;
      w_code_nxt     = r_err_code;
      w_push_c       = 1'b0;
      w_pop_c        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (tok_valid && r_tok_ready) begin
               if (!tok_is_op) begin
                  w_b_nxt     = tok_data;
                  w_wdata_nxt = tok_data;
                  w_dup_nxt   = 1'b0;
                  w_state_nxt = ST_PUSH;
               end else begin
                  w_op_nxt = w_tok_op;
                  if (w_tok_op == OP_ILL) begin
                     w_code_nxt  = ERR_ILL;
                     w_state_nxt = ST_ERR;
                  end else begin
                     w_state_nxt = ST_POP_B;
                  end
               end
            end
         end

         ST_POP_B: begin
            if (stk_empty) begin
               w_code_nxt  = ERR_UNDER;
               w_state_nxt = ST_ERR;
            end else begin
               w_pop_c = 1'b1;
               w_b_nxt = stk_rdata;
               if (is_binary(r_op)) begin
                  w_state_nxt = ST_POP_A;
               end else if ((r_op == OP_NEG) || (r_op == OP_DUP)) begin
                  w_state_nxt = ST_EXEC;
               end else if (r_op == OP_EMIT) begin
                  w_res_data_nxt = stk_rdata;
                  w_state_nxt    = ST_EMIT;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end

         ST_POP_A: begin
            if (stk_empty) begin
               w_code_nxt  = ERR_UNDER;
               w_state_nxt = ST_ERR;
            end else begin
               w_pop_c     = 1'b1;
               w_a_nxt     = stk_rdata;
               w_state_nxt = ST_EXEC;
            end
         end

         ST_EXEC: begin
            w_wdata_nxt = w_alu_c;
            w_dup_nxt   = (r_op == OP_DUP);
            w_state_nxt = ST_PUSH;
         end

         // A pending DUP copy re-enters PUSH for a second, separate visit.
         ST_PUSH: begin
            w_dup_nxt = 1'b0;
            if (stk_full) begin
               w_code_nxt  = ERR_OVER;
               w_state_nxt = ST_ERR;
            end else begin
               w_push_c    = 1'b1;
               w_state_nxt = r_dup_pend ? ST_PUSH : ST_IDLE;
            end
         end

         ST_EMIT: begin
            if (res_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_ERR: begin
            if (err_clr) begin
               w_code_nxt  = ERR_NONE;
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign tok_ready = r_tok_ready;
   assign stk_push  = w_push_c;
   assign stk_pop   = w_pop_c;
   assign stk_wdata = r_wdata;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign err       = r_err;
   assign err_code  = r_err_code;

endmodule
